serial_frame_sender: RTL and testbench

SERIAL_FRAME_SENDER -- requirements
Module: serial_frame_sender

---
 rtl/serial_pkg.sv | 15 +
 rtl/down_counter.sv | 29 ++
 rtl/serial_frame_sender.sv | 143 ++++++++++++++
 tb/tb_serial_frame_sender.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Types and constants shared by the serial frame sender and its receiving controller.
package serial_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPre,
    StLen,
    StPay,
    StGap
  } state_e;

  localparam int unsigned   PreambleW       = 4;
  localparam logic [3:0]    PreambleDefault = 4'b1101;

endpackage

// File: rtl/down_counter.sv
// Loadable down counter that saturates at zero; load has priority over decrement.
module down_counter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/serial_frame_sender.sv
// Serialises preamble, length field and payload MSB first, one bit per cycle,
// followed by a one-cycle done gap.
module serial_frame_sender
  import serial_pkg::*;
#(
  parameter int unsigned          DATA_W   = 16,
  parameter int unsigned          LEN_W    = 4,
  parameter logic [PreambleW-1:0] PREAMBLE = PreambleDefault
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic              ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              done
);

  localparam int unsigned PreIdxW = $clog2(PreambleW);
  localparam int unsigned LenIdxW = (LEN_W > 1) ? $clog2(LEN_W) : 1;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q;
  logic [LEN_W-1:0]   len_q;

  logic               cnt_load, cnt_dec, cnt_zero;
  logic [LEN_W-1:0]   cnt_load_val, cnt, bit_idx;

  logic               ser_out_d, ser_valid_d, done_d;
  logic               ser_out_q, ser_valid_q, done_q;

  down_counter #(
    .W (LEN_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      data_q      <= '0;
      len_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      if (state_q == StIdle && start) begin
        data_q <= data_in;
        len_q  <= len_in;
      end
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
    end
  end

  // Every state change reloads the counter; otherwise it counts down the current field.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StPre;
          cnt_load     = 1'b1;
          cnt_load_val = LEN_W'(PreambleW - 1);
        end
      end
      StPre: begin
        if (cnt_zero) begin
          state_d      = StLen;
          cnt_load     = 1'b1;
          cnt_load_val = LEN_W'(LEN_W - 1);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StLen: begin
        if (cnt_zero) begin
          state_d      = StPay;
          cnt_load     = 1'b1;
          cnt_load_val = len_q;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StPay: begin
        if (cnt_zero) begin
          state_d  = StGap;
          cnt_load = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      StGap: begin
        state_d  = StIdle;
        cnt_load = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state and bit index of the next cycle.
  always_comb begin
    bit_idx     = cnt_load ? cnt_load_val : cnt - LEN_W'(1);
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_d)
      StPre: begin
        ser_valid_d = 1'b1;
        ser_out_d   = PREAMBLE[bit_idx[PreIdxW-1:0]];
      end
      StLen: begin
        ser_valid_d = 1'b1;
        ser_out_d   = len_q[bit_idx[LenIdxW-1:0]];
      end
      StPay: begin
        ser_valid_d = 1'b1;
        ser_out_d   = data_q[bit_idx];
      end
      StGap:   done_d = 1'b1;
      default: ;
    endcase
  end

  assign ready     = (state_q == StIdle);
  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_sender.sv
// Self-checking bench for serial_frame_sender against a bit-list frame model.
module tb_serial_frame_sender;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] data_in;
  logic [3:0]  len_in;
  logic        ready, ser_out, ser_valid, done;

  int total = 0;
  int bad   = 0;

  // Bit c-1 holds the value observed in cycle k+c after acceptance edge k.
  logic [63:0] obs_out, obs_val, obs_done, obs_rdy;

  always #5 clk = ~clk;

  serial_frame_sender dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .len_in    (len_in),
    .ready     (ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .done      (done)
  );

  // Frame = preamble, length field, payload bits len..0, all MSB first.
  function automatic void model(input int l, input logic [15:0] d,
                                output logic [63:0] bits, output int n);
    logic [3:0] pre = 4'b1101;
    logic [3:0] lv;
    bit q[$];
    lv = 4'(l);
    for (int i = 3; i >= 0; i--) q.push_back(pre[i]);
    for (int i = 3; i >= 0; i--) q.push_back(lv[i]);
    for (int i = l; i >= 0; i--) q.push_back(d[i]);
    bits = '0;
    foreach (q[i]) bits[i] = q[i];
    n = q.size();
  endfunction

  // Caller raises start in the cycle before the acceptance edge.
  task automatic capture(input int ncyc, input bit hold, input int scr, input int abort_at);
    obs_out = '0; obs_val = '0; obs_done = '0; obs_rdy = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= ncyc; c++) begin
      start = hold ? 1'b1 : ((c <= scr) ? 1'($urandom) : 1'b0);
      if (c <= scr) begin
        data_in = 16'($urandom);
        len_in  = 4'($urandom);
      end
      rst = (c == abort_at);
      @(negedge clk);
      obs_out[c-1]  = ser_out;
      obs_val[c-1]  = ser_valid;
      obs_done[c-1] = done;
      obs_rdy[c-1]  = ready;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; data_in = 16'hBEEF; len_in = 4'd3;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset ready: got %b want 1", ready); end
    total++; if (ser_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", ser_valid); end
    total++; if (ser_out !== 1'b0) begin bad++; $display("FAIL reset ser_out: got %b want 0", ser_out); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    @(posedge clk); #1;
  endtask

  task automatic test_single(input string name, input int l, input logic [15:0] d, input bit scr);
    logic [63:0] bits;
    int n;
    model(l, d, bits, n);
    len_in = 4'(l); data_in = d; start = 1'b1;
    capture(n + 2, 1'b0, scr ? n + 1 : 0, 0);
    total++; if (obs_out !== bits) begin bad++;
      $display("FAIL %s ser_out: got %h want %h", name, obs_out, bits); end
    total++; if (obs_val !== (64'(1) << n) - 64'(1)) begin bad++;
      $display("FAIL %s valid: got %h want %h", name, obs_val, (64'(1) << n) - 64'(1)); end
    total++; if (obs_done !== 64'(1) << n) begin bad++;
      $display("FAIL %s done: got %h want %h", name, obs_done, 64'(1) << n); end
    total++; if (obs_rdy !== 64'(1) << (n + 1)) begin bad++;
      $display("FAIL %s ready: got %h want %h", name, obs_rdy, 64'(1) << (n + 1)); end
  endtask

  task automatic test_vector();
    test_single("vec_len2", 2, 16'h0005, 1'b0);
  endtask

  task automatic test_len_zero();
    test_single("len_zero", 0, 16'hFFFE, 1'b0);
  endtask

  task automatic test_len_max();
    test_single("len_max", 15, 16'hA5C3, 1'b0);
  endtask

  task automatic test_input_change();
    for (int i = 0; i < 8; i++) begin
      test_single("rand_scramble", int'($urandom_range(0, 15)), 16'($urandom), 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] bits, m;
    int n;
    int l;
    l = int'($urandom_range(0, 5));
    model(l, 16'h9A3C, bits, n);
    m = (64'(1) << n) - 64'(1);
    len_in = 4'(l); data_in = 16'h9A3C; start = 1'b1;
    capture(2 * n + 3, 1'b1, 0, 0);
    total++; if (obs_out !== (bits | (bits << (n + 2)))) begin bad++;
      $display("FAIL b2b ser_out: got %h want %h", obs_out, bits | (bits << (n + 2))); end
    total++; if (obs_val !== (m | (m << (n + 2)))) begin bad++;
      $display("FAIL b2b valid: got %h want %h", obs_val, m | (m << (n + 2))); end
    total++; if (obs_done !== ((64'(1) << n) | (64'(1) << (2 * n + 2)))) begin bad++;
      $display("FAIL b2b done: got %h want %h", obs_done,
               (64'(1) << n) | (64'(1) << (2 * n + 2))); end
    total++; if (obs_rdy !== 64'(1) << (n + 1)) begin bad++;
      $display("FAIL b2b ready: got %h want %h", obs_rdy, 64'(1) << (n + 1)); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [63:0] bits;
    int n;
    model(15, 16'h1234, bits, n);
    len_in = 4'd15; data_in = 16'h1234; start = 1'b1;
    capture(30, 1'b0, 0, 6);
    total++; if (obs_out !== (bits & 64'h3F)) begin bad++;
      $display("FAIL abort ser_out: got %h want %h", obs_out, bits & 64'h3F); end
    total++; if (obs_val !== 64'h3F) begin bad++;
      $display("FAIL abort valid: got %h want %h", obs_val, 64'h3F); end
    total++; if (obs_done !== 64'h0) begin bad++;
      $display("FAIL abort done: got %h want 0", obs_done); end
    total++; if (obs_rdy !== 64'h3FFF_FFC0) begin bad++;
      $display("FAIL abort ready: got %h want %h", obs_rdy, 64'h3FFF_FFC0); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; data_in = '0; len_in = '0;
    test_reset();
    test_vector();
    test_len_zero();
    test_len_max();
    test_input_change();
    test_back_to_back();
    test_abort();
    test_single("after_abort", 3, 16'h000A, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
